// File: rtl/rv_pkg.sv
// rv_pkg: definitions shared by the instruction fetch slice.
//   XLEN          default address / PC width
//   RESET_PC      default fetch address after reset
//   INST_W        instruction word width
//   fetch_entry_t {pc, inst} pair delivered to decode
//   fetch_state_e fetch controller states (RUN / FAULT)
//   is_misaligned true when the low PC bits are not word aligned
package rv_pkg;

  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam int INST_W = 32;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: DEPTH-entry synchronous FIFO with flush and occupancy count.
//   clk, rst_n   clock, asynchronous active-low reset (pointers/count only)
//   flush        empty the FIFO at the next edge; overrides push and pop
//   push         write push_data at the tail
//   push_data    W-bit entry
//   pop          drop the head entry
//   head_data    current head entry (read straight from storage)
//   count        number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module ifetch_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;

  assign full      = (count == CW'(DEPTH));
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // storage is datapath only; validity is tracked by count
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // the fetch credit limit must make these impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !flush && (count == '0)));

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch unit.
// Keeps a fetch PC, issues sequential word requests to instruction memory,
// buffers the in-order responses and presents {pc, instruction} to decode.
// A redirect flushes the buffer and discards every response still owed.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   redirect_valid    redirect fetch to redirect_pc this cycle
//   redirect_pc       new fetch address (low two bits nonzero -> fault)
//   imem_req_valid    request valid
//   imem_req_ready    memory accepts request
//   imem_req_addr     word address requested
//   imem_rsp_valid    in-order response valid
//   imem_rsp_data     instruction word
//   inst_valid        buffer head valid
//   inst_ready        decode accepts head
//   inst_data         head instruction
//   inst_pc           head instruction address
//   fetch_fault       misaligned redirect captured; fetch halted
// Optional build macro IFETCH_PERF_EN adds:
//   perf_fetched      instructions popped by decode (wraps)
//   perf_stall        cycles with inst_ready && !inst_valid (wraps)
module ifetch_unit
  import rv_pkg::*;
#(
  parameter int              XLEN     = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = rv_pkg::RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc,
  output logic              fetch_fault
`ifdef IFETCH_PERF_EN
  ,
  output logic [63:0]       perf_fetched,
  output logic [63:0]       perf_stall
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = XLEN + INST_W;

  fetch_state_e    state;
  fetch_state_e    state_nxt;
  logic            live;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   inflight_nxt;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   count;
  logic [CW:0]     used;
  logic            credit_ok;
  logic            accept;
  logic            push;
  logic            pop;
  logic [EW-1:0]   head;

  // ---- request side: credit and handshake ----
  // A slot freed by this cycle's pop is already available: the request
  // cannot return before the next edge, when the slot really is free. This
  // keeps the request stable once raised and sustains one fetch per cycle.
  assign used      = ({1'b0, inflight} + {1'b0, count}) - (CW+1)'(pop);
  assign credit_ok = used < (CW+1)'(DEPTH);
  assign accept    = imem_req_valid && imem_req_ready;
  assign imem_req_addr = fetch_pc;

  // ---- response side ----
  // Responses are discarded while drop is nonzero, and also when they
  // coincide with a redirect (the flush would throw them away anyway; the
  // redirect's drop count already excludes them).
  assign pop          = inst_valid && inst_ready;
  assign push         = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign inflight_nxt = inflight + CW'(accept) - CW'(imem_rsp_valid);

  // ---- fetch FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // ---- fetch FSM: next state ----
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = is_misaligned(redirect_pc[1:0]) ? ST_FAULT : ST_RUN;
    end
  end

  // ---- fetch FSM: outputs ----
  // live holds requests off while reset is asserted.
  always_comb begin
    fetch_fault    = (state == ST_FAULT);
    imem_req_valid = live && (state == ST_RUN) && !redirect_valid && credit_ok;
  end

  // ---- control registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live     <= 1'b0;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      live     <= 1'b1;
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop     <= inflight_nxt;
      end else begin
        if (accept) fetch_pc <= fetch_pc + XLEN'(4);
        if (push)   rsp_pc   <= rsp_pc + XLEN'(4);
        if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  // ---- instruction buffer ----
  ifetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({rsp_pc, imem_rsp_data}),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  assign inst_valid = (count != '0);
  assign inst_pc    = head[EW-1:INST_W];
  assign inst_data  = head[INST_W-1:0];

  a_rsp_owed: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (inflight != '0));

`ifdef IFETCH_PERF_EN
  // ---- performance counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (pop)                      perf_fetched <= perf_fetched + 64'd1;
      if (inst_ready && !inst_valid) perf_stall  <= perf_stall + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scoreboard bench for ifetch_unit.
// Expected program order comes from a simple model: after reset or an
// aligned redirect to P the delivered stream is P, P+4, P+8, ... with
// data = mem_word(pc); a misaligned redirect delivers nothing until the
// next aligned redirect. A memory model answers accepted requests in order.
module tb_ifetch_unit;
  import rv_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        fetch_fault;
`ifdef IFETCH_PERF_EN
  logic [63:0] perf_fetched;
  logic [63:0] perf_stall;
`endif

  always #5 clk = ~clk;

  ifetch_unit #(.XLEN(64), .RESET_PC(64'h0), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  typedef struct {
    logic [63:0] addr;
    int          rdy;
  } pend_t;

  pend_t       mem_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] next_pc;
  logic [63:0] exp_addr;
  logic [63:0] mon_e;
  bit          exp_fault;
  bit          mon_en = 1'b0;
  bit          redir_pend;
  logic [63:0] redir_addr;
  int vectors = 0, miscompares = 0;
  int cyc = 0, acc_cnt = 0, pop_cnt = 0;
  int req_pct = 100, ird_pct = 100, dly_min = 0, dly_max = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] h;
    h = a[33:2] * 32'h9E37_79B1;
    return h ^ a[63:32] ^ 32'h0BAD_F00D;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // one clock of stimulus: memory response, handshakes, optional redirect
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_q.size() > 0 && mem_q[0].rdy <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    imem_req_ready = int'($urandom_range(99, 0)) < req_pct;
    inst_ready     = int'($urandom_range(99, 0)) < ird_pct;
    redirect_valid = redir_pend;
    redirect_pc    = redir_addr;
    redir_pend     = 1'b0;
  endtask

  task automatic do_redirect(input logic [63:0] a);
    redir_pend = 1'b1;
    redir_addr = a;
    tick();
  endtask

  // monitor / scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check64("fetch_fault", {63'b0, fetch_fault}, {63'b0, exp_fault});
      if (exp_fault) check64("req_valid_in_fault", {63'b0, imem_req_valid}, 64'd0);
      if (imem_req_valid && imem_req_ready) begin
        check64("req_addr", imem_req_addr, exp_addr);
        exp_addr = exp_addr + 64'd4;
        mem_q.push_back('{imem_req_addr, cyc + 1 + int'($urandom_range(dly_max, dly_min))});
        acc_cnt++;
      end
      if (inst_valid && inst_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_inst: got pc %h, expected no instruction", inst_pc);
        end else begin
          mon_e = exp_q.pop_front();
          check64("inst_pc", inst_pc, mon_e);
          check64("inst_data", {32'b0, inst_data}, {32'b0, mem_word(mon_e)});
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_addr  = redirect_pc;
        next_pc   = redirect_pc;
        exp_fault = (redirect_pc[1:0] != 2'b00);
      end
      while (!exp_fault && exp_q.size() < 4) begin
        exp_q.push_back(next_pc);
        next_pc = next_pc + 64'd4;
      end
    end
  end

  initial begin
    int base;
    int p0;
    bit seen;
    logic [63:0] ra;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    inst_ready = 1'b0;
    next_pc = 64'h0;
    exp_addr = 64'h0;
    exp_fault = 1'b0;
    redir_pend = 1'b0;
    redir_addr = '0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check64("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
    check64("rst_inst_valid", {63'b0, inst_valid}, 64'd0);
    check64("rst_fetch_fault", {63'b0, fetch_fault}, 64'd0);
    check64("rst_req_addr", imem_req_addr, 64'h0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // zero-wait memory, decode always ready: one instruction per cycle
    req_pct = 100; ird_pct = 100; dly_min = 0; dly_max = 0;
    repeat (6) tick();
    base = pop_cnt;
    repeat (10) tick();
    check64("throughput_10_cycles", 64'(pop_cnt - base), 64'd10);

    // two responses in flight when redirecting to 0x100
    dly_min = 4; dly_max = 4;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (mem_q.size() == 2) seen = 1'b1;
    end
    check64("two_in_flight_reached", {63'b0, seen}, 64'd1);
    dly_min = 0; dly_max = 0;
    do_redirect(64'h100);
    base = pop_cnt;
    repeat (20) tick();
    check64("progress_after_0x100", {63'b0, pop_cnt > base}, 64'd1);

    // decode stalled: exactly DEPTH requests, then one more per pop
    ird_pct = 0;
    do_redirect(64'h1000);
    base = acc_cnt;
    repeat (12) tick();
    #2;
    check64("stall_accepts", 64'(acc_cnt - base), 64'(DEPTH));
    check64("stall_req_valid", {63'b0, imem_req_valid}, 64'd0);
    ird_pct = 100;
    tick();
    ird_pct = 0;
    repeat (5) tick();
    check64("one_pop_one_req", 64'(acc_cnt - base), 64'(DEPTH + 1));
    ird_pct = 100;
    repeat (10) tick();

    // misaligned redirect, misaligned again while faulted, then recover
    do_redirect(64'h102);
    tick();
    #2;
    check64("fault_set", {63'b0, fetch_fault}, 64'd1);
    check64("fault_no_req", {63'b0, imem_req_valid}, 64'd0);
    repeat (3) tick();
    do_redirect(64'h3);
    repeat (3) tick();
    #2;
    check64("fault_held", {63'b0, fetch_fault}, 64'd1);
    do_redirect(64'h200);
    tick();
    #2;
    check64("fault_cleared", {63'b0, fetch_fault}, 64'd0);
    base = pop_cnt;
    repeat (10) tick();
    check64("progress_after_0x200", {63'b0, pop_cnt > base}, 64'd1);

    // PC wrap past the top of the address space
    do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    base = pop_cnt;
    repeat (10) tick();
    check64("progress_after_wrap", {63'b0, pop_cnt > base}, 64'd1);

    // random backpressure, response delay and redirects
    req_pct = 60; ird_pct = 70; dly_min = 0; dly_max = 3;
    p0 = pop_cnt;
    for (int i = 0; i < 30000 && (pop_cnt - p0) < 1000; i++) begin
      if (exp_fault && $urandom_range(9, 0) == 0) begin
        ra = {$urandom(), $urandom()} & ~64'h3;
        do_redirect(ra);
      end else if (!exp_fault && $urandom_range(99, 0) == 0) begin
        ra = {$urandom(), $urandom()};
        if ($urandom_range(7, 0) != 0) ra = ra & ~64'h3;
        if ($urandom_range(7, 0) == 0) ra = 64'hFFFF_FFFF_FFFF_FFF0;
        do_redirect(ra);
      end else begin
        tick();
      end
    end
    check64("random_1000_insts", {63'b0, (pop_cnt - p0) >= 1000}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
